blind_pixel_ctrl: RTL and testbench
===================================

Name: blind_pixel_ctrl

Overview:
Streaming controller that corrects dead ("blind") sensor pixels in an Avalon-ST video stream. It sequences the read-only side of the dual-port blind-pixel table RAM, walking a raster-sorted list of defect coordinates in step with the incoming frame. Each pixel whose coordinate matches the current table entry is replaced by the previous output pixel. Software fills the table through the RAM's other port; this block only reads it.

Parameters:
DATA_WIDTH, 8, pixel/symbol width of the video stream
ADDR_WIDTH, 8, table RAM address width (up to 256 entries)
COORD_WIDTH, 16, width of the x/y coordinate fields and counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_enable  in  1  1 = correct pixels, 0 = pure pass-through; sampled at video SOP only
cfg_width  in  COORD_WIDTH  active pixels per line, ≥1
cfg_count  in  ADDR_WIDTH+1  number of valid table entries, 0..2^ADDR_WIDTH
ram_address  out  ADDR_WIDTH  table read address; registered inside the RAM, read data valid the following cycle
ram_readdata  in  32  table word: [31:16] = y, [15:0] = x; fields beyond COORD_WIDTH ignored
din_data  in  DATA_WIDTH  sink data
din_valid  in  1  sink valid
din_sop  in  1  sink startofpacket
din_eop  in  1  sink endofpacket
din_ready  out  1  sink ready
dout_data  out  DATA_WIDTH  source data
dout_valid  out  1  source valid
dout_sop  out  1  source startofpacket
dout_eop  out  1  source endofpacket
dout_ready  in  1  source ready
frame_hits  out  ADDR_WIDTH+1  pixels replaced in the last completed video frame
frame_done  out  1  one-cycle pulse when the EOP of a video packet is transferred on the source

Behaviour:
- Reset values: dout_valid, dout_sop, dout_eop, din_ready, frame_done = 0; dout_data, ram_address, frame_hits = 0; FSM = IDLE; x = y = 0; prev_pix = 0.
- Output stage: one register. A sink beat is accepted (din_valid & din_ready) only when the output register is empty or is being drained in the same cycle. Accepted beats appear on dout one cycle later. Source data is held stable while dout_valid & !dout_ready.
- Packet type: the low 4 bits of the SOP beat are the type. Type 0 = video. Any other type is passed through unchanged, with no table access.
- FSM:
  - IDLE: din_ready = 1. On an SOP beat of type 0 with cfg_enable = 1 and cfg_count ≠ 0: forward the beat, set ptr = 0, go to FETCH. On type 0 otherwise: forward the beat, go to RUN with no active entry. Any other type goes to PASS.
  - PASS: forward beats until an EOP beat is transferred, then go to IDLE.
  - FETCH: din_ready = 0; ram_address = ptr; go to WAIT.
  - WAIT: din_ready = 0; latch ram_readdata into the entry register; entry_valid = 1; go to RUN.
  - RUN: on each accepted beat:
    - if entry_valid and (x, y) == entry: output prev_pix instead of din_data, increment the hit counter, ptr = ptr + 1. If ptr + 1 < cfg_count go to FETCH; else entry_valid = 0 and stay in RUN.
    - else: output din_data.
    - prev_pix <= the data actually output.
    - Advance x. When x == cfg_width − 1: x = 0, y = y + 1.
    - On an EOP beat: frame_hits <= hit counter, frame_done pulses when that beat is transferred on the source, then go to IDLE. EOP takes priority over FETCH: a match on the EOP beat still replaces the pixel, but no fetch follows.
- Video SOP clears x, y, hit counter and prev_pix. The first pixel of a frame, if blind, is replaced with 0.
- Throughput cost is 2 stall cycles per replaced pixel. Adjacent blind pixels are handled because the stall precedes the next beat.
- The table must be strictly ascending in raster order. An entry behind the current position never matches, and later entries in that frame are not applied. This is defined behaviour, not an error.
- An EOP arriving before width × height pixels ends the frame normally. Counters and the FSM reset at the next SOP.
- An SOP arriving mid-packet without a preceding EOP is treated as a new packet: state returns through the IDLE decision in the same cycle.
- Asynchronous reset mid-frame returns to the reset state immediately. The partial frame is dropped and frame_hits is cleared.

Test Plan:
- Pass-through: cfg_enable = 0, 4×2 frame of data 1..8 → output 1..8 unchanged, frame_hits = 0, no FETCH cycles.
- Single hit: table {(y=0, x=2)}, cfg_count = 1, width 4, data 10,20,30,40 → output 10,20,20,40; din_ready low exactly 2 cycles after SOP; frame_hits = 1.
- Adjacent and line wrap: entries (0,3),(1,0),(1,1), width 4, data 1..8 → output 1,2,3,3,3,3,7,8; frame_hits = 3.
- Backpressure: dout_ready toggling 1010… during the single-hit case → same data sequence, no beat lost or duplicated, dout held stable while stalled.
- Non-video packet: type-0xF control packet of 3 beats, then a video frame → control beats unchanged with no table reads; the video frame is then corrected normally.
- Reset mid-frame: assert rst_n = 0 after 3 beats, release, send a new frame with one hit → all outputs at reset values during reset; the new frame gives frame_hits = 1.

Source files
------------

// File: rtl/blind_pixel_ctrl.sv
// Blind-pixel correction for an Avalon-ST video stream: walks a raster-sorted defect
// table in step with the incoming frame and replaces each listed pixel with the previous output.
module blind_pixel_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int COORD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_enable,
  input  logic [COORD_WIDTH-1:0]  cfg_width,
  input  logic [ADDR_WIDTH:0]     cfg_count,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  input  logic [31:0]             ram_readdata,
  input  logic [DATA_WIDTH-1:0]   din_data,
  input  logic                    din_valid,
  input  logic                    din_sop,
  input  logic                    din_eop,
  output logic                    din_ready,
  output logic [DATA_WIDTH-1:0]   dout_data,
  output logic                    dout_valid,
  output logic                    dout_sop,
  output logic                    dout_eop,
  input  logic                    dout_ready,
  output logic [ADDR_WIDTH:0]     frame_hits,
  output logic                    frame_done
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PASS  = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t                  state_q, state_d, eff_state_s;
  logic                    alive_q, alive_d;
  logic [CW-1:0]           ptr_q, ptr_d, ptr_inc_s;
  logic [CW-1:0]           hit_cnt_q, hit_cnt_d;
  logic [CW-1:0]           frame_hits_q, frame_hits_d;
  logic [COORD_WIDTH-1:0]  entry_x_q, entry_x_d;
  logic [COORD_WIDTH-1:0]  entry_y_q, entry_y_d;
  logic                    entry_valid_q, entry_valid_d;
  logic [COORD_WIDTH-1:0]  x_q, x_d;
  logic [COORD_WIDTH-1:0]  y_q, y_d;
  logic [DATA_WIDTH-1:0]   prev_pix_q, prev_pix_d;
  logic [ADDR_WIDTH-1:0]   ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0]   dout_data_q, dout_data_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    dout_sop_q, dout_sop_d;
  logic                    dout_eop_q, dout_eop_d;
  logic                    vid_eop_q, vid_eop_d;

  logic                    stall_ok_s;
  logic                    din_ready_s;
  logic                    accept_s;
  logic                    hit_s;
  logic [DATA_WIDTH-1:0]   out_data_s;
  logic                    out_vid_eop_s;

  // Handshake: a beat enters only when the output register is free or draining this cycle.
  always_comb begin
    stall_ok_s  = ~dout_valid_q | dout_ready;
    din_ready_s = alive_q & stall_ok_s & (state_q != S_FETCH) & (state_q != S_WAIT);
    accept_s    = din_valid & din_ready_s;
    ptr_inc_s   = ptr_q + CW'(1);
    if (accept_s && din_sop) begin
      eff_state_s = S_IDLE;
    end else begin
      eff_state_s = state_q;
    end
  end

  // Controller next-state: packet classification, table walk and pixel substitution.
  always_comb begin
    state_d       = state_q;
    alive_d       = 1'b1;
    ptr_d         = ptr_q;
    hit_cnt_d     = hit_cnt_q;
    frame_hits_d  = frame_hits_q;
    entry_x_d     = entry_x_q;
    entry_y_d     = entry_y_q;
    entry_valid_d = entry_valid_q;
    x_d           = x_q;
    y_d           = y_q;
    prev_pix_d    = prev_pix_q;
    out_data_s    = din_data;
    out_vid_eop_s = 1'b0;
    hit_s         = 1'b0;

    case (eff_state_s)
      S_IDLE: begin
        if (accept_s && din_sop && (din_data[3:0] == 4'd0)) begin
          x_d           = '0;
          y_d           = '0;
          hit_cnt_d     = '0;
          prev_pix_d    = '0;
          ptr_d         = '0;
          entry_valid_d = 1'b0;
          if (din_eop) begin
            // Header-only video packet: an empty frame.
            frame_hits_d  = '0;
            out_vid_eop_s = 1'b1;
            state_d       = S_IDLE;
          end else if (cfg_enable && (cfg_count != '0)) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_RUN;
          end
        end else if (accept_s && din_sop) begin
          if (din_eop) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PASS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PASS: begin
        if (accept_s && din_eop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PASS;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        entry_x_d     = ram_readdata[COORD_WIDTH-1:0];
        entry_y_d     = ram_readdata[16 +: COORD_WIDTH];
        entry_valid_d = 1'b1;
        state_d       = S_RUN;
      end
      S_RUN: begin
        if (accept_s) begin
          hit_s = entry_valid_q && (x_q == entry_x_q) && (y_q == entry_y_q);
          if (hit_s) begin
            out_data_s = prev_pix_q;
            hit_cnt_d  = hit_cnt_q + CW'(1);
            ptr_d      = ptr_inc_s;
            if ((ptr_inc_s < cfg_count) && !din_eop) begin
              state_d = S_FETCH;
            end else begin
              entry_valid_d = 1'b0;
            end
          end else begin
            out_data_s = din_data;
          end
          prev_pix_d = out_data_s;
          if (x_q == (cfg_width - COORD_WIDTH'(1))) begin
            x_d = '0;
            y_d = y_q + COORD_WIDTH'(1);
          end else begin
            x_d = x_q + COORD_WIDTH'(1);
          end
          if (din_eop) begin
            // Include a hit on the final beat itself.
            frame_hits_d  = hit_s ? (hit_cnt_q + CW'(1)) : hit_cnt_q;
            out_vid_eop_s = 1'b1;
            state_d       = S_IDLE;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ram_address_d = ptr_d[ADDR_WIDTH-1:0];
  end

  // Output register: load on accept, empty when drained, hold while stalled.
  always_comb begin
    dout_data_d  = dout_data_q;
    dout_valid_d = dout_valid_q;
    dout_sop_d   = dout_sop_q;
    dout_eop_d   = dout_eop_q;
    vid_eop_d    = vid_eop_q;
    if (accept_s) begin
      dout_data_d  = out_data_s;
      dout_valid_d = 1'b1;
      dout_sop_d   = din_sop;
      dout_eop_d   = din_eop;
      vid_eop_d    = out_vid_eop_s;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
      vid_eop_d    = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      alive_q       <= 1'b0;
      ptr_q         <= '0;
      hit_cnt_q     <= '0;
      frame_hits_q  <= '0;
      entry_x_q     <= '0;
      entry_y_q     <= '0;
      entry_valid_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      prev_pix_q    <= '0;
      ram_address_q <= '0;
      dout_data_q   <= '0;
      dout_valid_q  <= 1'b0;
      dout_sop_q    <= 1'b0;
      dout_eop_q    <= 1'b0;
      vid_eop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      alive_q       <= alive_d;
      ptr_q         <= ptr_d;
      hit_cnt_q     <= hit_cnt_d;
      frame_hits_q  <= frame_hits_d;
      entry_x_q     <= entry_x_d;
      entry_y_q     <= entry_y_d;
      entry_valid_q <= entry_valid_d;
      x_q           <= x_d;
      y_q           <= y_d;
      prev_pix_q    <= prev_pix_d;
      ram_address_q <= ram_address_d;
      dout_data_q   <= dout_data_d;
      dout_valid_q  <= dout_valid_d;
      dout_sop_q    <= dout_sop_d;
      dout_eop_q    <= dout_eop_d;
      vid_eop_q     <= vid_eop_d;
    end
  end

  assign din_ready   = din_ready_s;
  assign ram_address = ram_address_q;
  assign dout_data   = dout_data_q;
  assign dout_valid  = dout_valid_q;
  assign dout_sop    = dout_sop_q;
  assign dout_eop    = dout_eop_q;
  assign frame_hits  = frame_hits_q;
  // Pulses in the cycle the video EOP actually leaves the source port.
  assign frame_done  = dout_valid_q & dout_ready & vid_eop_q;

endmodule

// File: tb/tb_blind_pixel_ctrl.sv
// Directed scoreboard bench for blind_pixel_ctrl with a behavioural table RAM.
module tb_blind_pixel_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_width = 16'd4;
  logic [8:0]  cfg_count = 9'd0;
  logic [7:0]  ram_address;
  logic [31:0] ram_readdata = 32'd0;
  logic [7:0]  din_data = 8'd0;
  logic        din_valid = 1'b0;
  logic        din_sop = 1'b0;
  logic        din_eop = 1'b0;
  logic        din_ready;
  logic [7:0]  dout_data;
  logic        dout_valid;
  logic        dout_sop;
  logic        dout_eop;
  logic        dout_ready = 1'b1;
  logic [8:0]  frame_hits;
  logic        frame_done;

  logic [31:0] tbl [0:255];
  logic [9:0]  sbq [$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          stall_cnt = 0;
  int          done_cnt = 0;
  logic        sb_en = 1'b1;
  logic        bp_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'd0;
  logic [9:0]  e;

  blind_pixel_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .COORD_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_width(cfg_width),
    .cfg_count(cfg_count), .ram_address(ram_address), .ram_readdata(ram_readdata),
    .din_data(din_data), .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop),
    .din_ready(din_ready), .dout_data(dout_data), .dout_valid(dout_valid),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_ready(dout_ready),
    .frame_hits(frame_hits), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_readdata <= tbl[ram_address];

  always @(posedge clk) begin
    #1;
    dout_ready = bp_en ? ~dout_ready : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops, hold check, stall and frame_done counting.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(dout_valid), 32'd1);
        chk("hold_data", 32'(dout_data), 32'(prev_data));
      end
      if (dout_valid && dout_ready && sb_en) begin
        chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("out_data", 32'(dout_data), 32'(e[7:0]));
          chk("out_sop", 32'(dout_sop), 32'(e[9]));
          chk("out_eop", 32'(dout_eop), 32'(e[8]));
        end
      end
      if (frame_done) done_cnt++;
      if (!din_ready && (!dout_valid || dout_ready)) stall_cnt++;
      prev_stall = dout_valid && !dout_ready;
      prev_data  = dout_data;
    end
  end

  // Expects to be called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input logic [7:0] d, input logic s, input logic eo, input logic [7:0] exp_d);
    int t;
    sbq.push_back({s, eo, exp_d});
    din_data = d; din_sop = s; din_eop = eo; din_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!din_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk("accept_timeout", 32'(t < 100), 32'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall_cnt = 0;
    done_cnt  = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = 32'hFFFF_FFFF;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_dout_data", 32'(dout_data), 32'd0);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    chk("rst_frame_hits", 32'(frame_hits), 32'd0);
    chk("rst_sop_eop", 32'({dout_sop, dout_eop}), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass-through with a loaded table but correction disabled
    tbl[0] = {16'd0, 16'd2};
    cfg_count = 9'd1; cfg_enable = 1'b0;
    clr();
    send(8'd0, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, (i == 8), 8'(i));
    drain();
    chk("pt_hits", 32'(frame_hits), 32'd0);
    chk("pt_stalls", 32'(stall_cnt), 32'd0);
    chk("pt_done", 32'(done_cnt), 32'd1);

    // Single hit at (0,2)
    cfg_enable = 1'b1;
    clr();
    send(8'd0, 1'b1, 1'b0, 8'd0);
    send(8'd10, 1'b0, 1'b0, 8'd10);
    send(8'd20, 1'b0, 1'b0, 8'd20);
    send(8'd30, 1'b0, 1'b0, 8'd20);
    send(8'd40, 1'b0, 1'b1, 8'd40);
    drain();
    chk("single_hits", 32'(frame_hits), 32'd1);
    chk("single_stalls", 32'(stall_cnt), 32'd2);
    chk("single_done", 32'(done_cnt), 32'd1);

    // Adjacent entries across a line wrap
    tbl[0] = {16'd0, 16'd3}; tbl[1] = {16'd1, 16'd0}; tbl[2] = {16'd1, 16'd1};
    cfg_count = 9'd3;
    clr();
    send(8'd0, 1'b1, 1'b0, 8'd0);
    send(8'd1, 1'b0, 1'b0, 8'd1);
    send(8'd2, 1'b0, 1'b0, 8'd2);
    send(8'd3, 1'b0, 1'b0, 8'd3);
    send(8'd4, 1'b0, 1'b0, 8'd3);
    send(8'd5, 1'b0, 1'b0, 8'd3);
    send(8'd6, 1'b0, 1'b0, 8'd3);
    send(8'd7, 1'b0, 1'b0, 8'd7);
    send(8'd8, 1'b0, 1'b1, 8'd8);
    drain();
    chk("adj_hits", 32'(frame_hits), 32'd3);
    chk("adj_stalls", 32'(stall_cnt), 32'd6);

    // Single hit under alternating backpressure
    tbl[0] = {16'd0, 16'd2}; cfg_count = 9'd1;
    bp_en = 1'b1;
    clr();
    send(8'd0, 1'b1, 1'b0, 8'd0);
    send(8'd10, 1'b0, 1'b0, 8'd10);
    send(8'd20, 1'b0, 1'b0, 8'd20);
    send(8'd30, 1'b0, 1'b0, 8'd20);
    send(8'd40, 1'b0, 1'b1, 8'd40);
    drain();
    bp_en = 1'b0;
    chk("bp_hits", 32'(frame_hits), 32'd1);
    chk("bp_done", 32'(done_cnt), 32'd1);

    // Control packet passes untouched, no table walk
    clr();
    send(8'h0F, 1'b1, 1'b0, 8'h0F);
    send(8'h33, 1'b0, 1'b0, 8'h33);
    send(8'h44, 1'b0, 1'b1, 8'h44);
    drain();
    chk("ctl_stalls", 32'(stall_cnt), 32'd0);
    chk("ctl_done", 32'(done_cnt), 32'd0);
    chk("ctl_hits_kept", 32'(frame_hits), 32'd1);
    clr();
    send(8'd0, 1'b1, 1'b0, 8'd0);
    send(8'd5, 1'b0, 1'b0, 8'd5);
    send(8'd6, 1'b0, 1'b0, 8'd6);
    send(8'd7, 1'b0, 1'b0, 8'd6);
    send(8'd8, 1'b0, 1'b1, 8'd8);
    drain();
    chk("ctl_vid_hits", 32'(frame_hits), 32'd1);
    chk("ctl_vid_stalls", 32'(stall_cnt), 32'd2);

    // Blind first pixel takes the cleared history value
    tbl[0] = {16'd0, 16'd0};
    clr();
    send(8'd0, 1'b1, 1'b0, 8'd0);
    send(8'd9, 1'b0, 1'b0, 8'd0);
    send(8'd10, 1'b0, 1'b0, 8'd10);
    send(8'd11, 1'b0, 1'b0, 8'd11);
    send(8'd12, 1'b0, 1'b1, 8'd12);
    drain();
    chk("first_hits", 32'(frame_hits), 32'd1);

    // Reset mid-frame
    tbl[0] = {16'd0, 16'd2};
    sb_en = 1'b0;
    send(8'd0, 1'b1, 1'b0, 8'd0);
    send(8'd1, 1'b0, 1'b0, 8'd1);
    send(8'd2, 1'b0, 1'b0, 8'd2);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_ready", 32'(din_ready), 32'd0);
    chk("mid_rst_hits", 32'(frame_hits), 32'd0);
    chk("mid_rst_addr", 32'(ram_address), 32'd0);
    chk("mid_rst_data", 32'(dout_data), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1; sb_en = 1'b1;
    @(posedge clk); #1;
    clr();
    send(8'd0, 1'b1, 1'b0, 8'd0);
    send(8'd10, 1'b0, 1'b0, 8'd10);
    send(8'd20, 1'b0, 1'b0, 8'd20);
    send(8'd30, 1'b0, 1'b0, 8'd20);
    send(8'd40, 1'b0, 1'b1, 8'd40);
    drain();
    chk("post_rst_hits", 32'(frame_hits), 32'd1);
    chk("post_rst_done", 32'(done_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
